// File: rtl/multichannel_period_meter.sv
// Multichannel period meter: per-channel edge-to-edge period counting with glitch rejection,
// loss-of-signal timeout, IIR smoothing, and a round-robin valid/ready result stream.
module multichannel_period_meter #(
    parameter int CHANNELS       = 2,
    parameter int COUNTER_BITS   = 14,
    parameter int FILTER_K_SHIFT = 5,
    parameter int MIN_PERIOD     = 4
) (
    input  logic                                   CLK,
    input  logic                                   RESETN,
    input  logic [CHANNELS-1:0]                    FREQ_IN,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic [2:0]                             OUT_CHANNEL,
    output logic [COUNTER_BITS-1:0]                OUT_RAW,
    output logic [COUNTER_BITS+FILTER_K_SHIFT-1:0] OUT_FILTERED,
    output logic                                   OUT_TIMEOUT,
    output logic [CHANNELS-1:0]                    OVERRUN,
    input  logic                                   OVERRUN_CLEAR
);
    localparam int CB = COUNTER_BITS;
    localparam int K  = FILTER_K_SHIFT;
    localparam int FW = CB + K;
    localparam logic [CB-1:0] MAX   = {CB{1'b1}};
    localparam logic [CB:0]   MIN_P = (CB + 1)'(MIN_PERIOD);

    // Output handshake: a beat transfers on a CLK edge where OUT_VALID=1 and OUT_READY=1;
    // while OUT_VALID=1 and OUT_READY=0 every OUT_* field is held unchanged.

    logic [CHANNELS-1:0] sync1, sync2, sync3, rise;
    logic [CHANNELS-1:0] armed, fvalid, pend, pend_to;
    logic [CB-1:0]       cnt       [CHANNELS];
    logic [FW-1:0]       y         [CHANNELS];
    logic [CB-1:0]       pend_raw  [CHANNELS];
    logic [FW-1:0]       pend_filt [CHANNELS];

    logic [CHANNELS-1:0] edge_ok, cap, cap_to, gnt_hit;
    logic [CB-1:0]       cap_raw  [CHANNELS];
    logic [FW-1:0]       cap_filt [CHANNELS];

    logic [2:0]    last_ch, gnt_ch;
    logic          gnt_found, fire;
    logic [CB-1:0] sel_raw;
    logic [FW-1:0] sel_filt;
    logic          sel_to;

    assign rise = sync2 & ~sync3;

    // Capture decision and filter update per channel; a glitch edge leaves every state untouched.
    always_comb begin
        logic [CB:0]   p_ext;
        logic [CB-1:0] p;
        p_ext = '0;
        p     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            p_ext       = {1'b0, cnt[i]} + (CB + 1)'(1);
            p           = p_ext[CB] ? MAX : p_ext[CB-1:0];
            edge_ok[i]  = rise[i] && (p_ext >= MIN_P);
            cap_to[i]   = !edge_ok[i] && armed[i] && (cnt[i] == MAX);
            cap[i]      = (edge_ok[i] && armed[i]) || cap_to[i];
            cap_raw[i]  = cap_to[i] ? MAX : p;
            if (cap_to[i])
                cap_filt[i] = '0;
            else if (fvalid[i])
                cap_filt[i] = y[i] - (y[i] >> K) + FW'(p);
            else
                cap_filt[i] = {p, {K{1'b0}}};
        end
    end

    // Round-robin search begins at the channel after the one granted last.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_ch    = last_ch;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last_ch) + i) % CHANNELS;
            for (int j = 0; j < CHANNELS; j++) begin
                if (!gnt_found && (j == idx) && pend[j]) begin
                    gnt_found = 1'b1;
                    gnt_ch    = 3'(j);
                end
            end
        end
    end

    assign fire = gnt_found && (!OUT_VALID || OUT_READY);

    always_comb begin
        sel_raw  = '0;
        sel_filt = '0;
        sel_to   = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            gnt_hit[j] = fire && (gnt_ch == 3'(j));
            if (gnt_ch == 3'(j)) begin
                sel_raw  = pend_raw[j];
                sel_filt = pend_filt[j];
                sel_to   = pend_to[j];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            armed        <= '0;
            fvalid       <= '0;
            pend         <= '0;
            pend_to      <= '0;
            OVERRUN      <= '0;
            OUT_VALID    <= 1'b0;
            OUT_CHANNEL  <= '0;
            OUT_RAW      <= '0;
            OUT_FILTERED <= '0;
            OUT_TIMEOUT  <= 1'b0;
            last_ch      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]       <= '0;
                y[i]         <= '0;
                pend_raw[i]  <= '0;
                pend_filt[i] <= '0;
            end
        end else begin
            sync1 <= FREQ_IN;
            sync2 <= sync1;
            sync3 <= sync2;
            if (OVERRUN_CLEAR)
                OVERRUN <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (edge_ok[i]) begin
                    cnt[i]   <= '0;
                    armed[i] <= 1'b1;
                end else if (cnt[i] != MAX) begin
                    cnt[i] <= cnt[i] + CB'(1);
                end
                if (cap_to[i]) begin
                    armed[i]  <= 1'b0;
                    fvalid[i] <= 1'b0;
                end else if (cap[i]) begin
                    y[i]      <= cap_filt[i];
                    fvalid[i] <= 1'b1;
                end
                // A slot being granted this cycle hands its old value out, so refilling it is no loss.
                if (cap[i]) begin
                    pend[i]      <= 1'b1;
                    pend_raw[i]  <= cap_raw[i];
                    pend_filt[i] <= cap_filt[i];
                    pend_to[i]   <= cap_to[i];
                    if (pend[i] && !gnt_hit[i])
                        OVERRUN[i] <= 1'b1;
                end else if (gnt_hit[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (fire) begin
                OUT_VALID    <= 1'b1;
                OUT_CHANNEL  <= gnt_ch;
                OUT_RAW      <= sel_raw;
                OUT_FILTERED <= sel_filt;
                OUT_TIMEOUT  <= sel_to;
                last_ch      <= gnt_ch;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multichannel_period_meter.sv
// Scoreboard bench for multichannel_period_meter: directed edge patterns push hand-computed
// beats into exp_q; a monitor compares every presented beat against the queue head.
module tb_multichannel_period_meter;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        f0 = 1'b0, f1 = 1'b0;
    logic [1:0]  freq_in;
    logic        out_valid, out_ready = 1'b1, out_timeout, overrun_clear = 1'b0;
    logic [2:0]  out_channel;
    logic [13:0] out_raw;
    logic [18:0] out_filtered;
    logic [1:0]  overrun;

    assign freq_in = {f1, f0};

    multichannel_period_meter #(
        .CHANNELS(2), .COUNTER_BITS(14), .FILTER_K_SHIFT(5), .MIN_PERIOD(4)
    ) dut (
        .CLK(clk), .RESETN(resetn), .FREQ_IN(freq_in),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CHANNEL(out_channel),
        .OUT_RAW(out_raw), .OUT_FILTERED(out_filtered), .OUT_TIMEOUT(out_timeout),
        .OVERRUN(overrun), .OVERRUN_CLEAR(overrun_clear)
    );

    always #5 clk = ~clk;

    logic [36:0] exp_q[$];
    logic [36:0] got, exp_v;
    int checks = 0, errors = 0, beats = 0, beats_before = 0;

    function automatic logic [36:0] pack(input logic [2:0] ch, input logic [13:0] raw,
                                         input logic [18:0] filt, input logic to);
        return {ch, raw, filt, to};
    endfunction

    // Monitor: samples mid low phase, after the negedge input updates and well before posedge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (resetn && out_valid) begin
                got = pack(out_channel, out_raw, out_filtered, out_timeout);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got ch=%0d raw=%0d filt=%0d to=%0d, expected no beat",
                             out_channel, out_raw, out_filtered, out_timeout);
                    if (out_ready) beats++;
                end else begin
                    exp_v = exp_q[0];
                    if (got !== exp_v) begin
                        errors++;
                        $display("FAIL %s: got ch=%0d raw=%0d filt=%0d to=%0d, expected ch=%0d raw=%0d filt=%0d to=%0d",
                                 out_ready ? "beat" : "stall_hold", got[36:34], got[33:20], got[19:1], got[0],
                                 exp_v[36:34], exp_v[33:20], exp_v[19:1], exp_v[0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_f(input int ch, input logic v);
        if (ch == 0) f0 = v;
        else f1 = v;
    endtask

    // n rising edges, gap CLK cycles apart; the trailing gap is waited out too. Call at a negedge.
    task automatic run_edges(input int ch, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            set_f(ch, 1'b1);
            @(negedge clk);
            set_f(ch, 1'b0);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d beats still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        f0 = 1'b0;
        f1 = 1'b0;
        cyc(3);
        exp_q.delete();
        resetn = 1'b1;
        cyc(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 resetn = 1'b0;
        cyc(3);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_channel", 32'(out_channel), 0);
        check("rst_raw", 32'(out_raw), 0);
        check("rst_filtered", 32'(out_filtered), 0);
        check("rst_timeout", 32'(out_timeout), 0);
        check("rst_overrun", 32'(overrun), 0);
        resetn = 1'b1;
        cyc(10);

        // Steady 100-cycle period, then a step to 60
        repeat (5) exp_q.push_back(pack(0, 100, 3200, 0));
        exp_q.push_back(pack(0, 60, 3160, 0));
        exp_q.push_back(pack(0, 60, 3122, 0));
        exp_q.push_back(pack(0, 60, 3085, 0));
        exp_q.push_back(pack(0, 60, 3049, 0));
        exp_q.push_back(pack(0, 60, 3014, 0));
        run_edges(0, 100, 5);
        run_edges(0, 60, 6);
        drain("step_drain", 50);
        do_reset();

        // Loss of signal on ch1, then re-arm and a fresh filter
        exp_q.push_back(pack(1, 14'd16383, 0, 1));
        run_edges(1, 50, 1);
        drain("timeout_drain", 17000);
        exp_q.push_back(pack(1, 200, 6400, 0));
        run_edges(1, 200, 2);
        drain("rearm_drain", 50);
        do_reset();

        // Back-pressure with both channels capturing
        out_ready = 1'b0;
        exp_q.push_back(pack(1, 80, 2560, 0));
        exp_q.push_back(pack(0, 50, 3150, 0));
        fork
            begin
                run_edges(0, 100, 1);
                run_edges(0, 50, 2);
            end
            run_edges(1, 80, 2);
        join
        check("overrun_set", 32'(overrun), 1);
        out_ready = 1'b1;
        drain("stall_drain", 20);
        check("overrun_sticky", 32'(overrun), 1);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        @(negedge clk);
        check("overrun_cleared", 32'(overrun), 0);
        do_reset();

        // Glitch edge 2 cycles after a valid edge
        repeat (2) exp_q.push_back(pack(0, 100, 3200, 0));
        run_edges(0, 100, 1);
        run_edges(0, 2, 1);
        run_edges(0, 98, 2);
        drain("glitch_drain", 20);
        do_reset();

        // Reset while a beat is held
        out_ready = 1'b0;
        exp_q.push_back(pack(0, 100, 3200, 0));
        run_edges(0, 100, 2);
        check("held_valid", 32'(out_valid), 1);
        #2 resetn = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_channel", 32'(out_channel), 0);
        check("async_raw", 32'(out_raw), 0);
        check("async_filtered", 32'(out_filtered), 0);
        check("async_timeout", 32'(out_timeout), 0);
        check("async_overrun", 32'(overrun), 0);
        exp_q.delete();
        cyc(3);
        resetn = 1'b1;
        out_ready = 1'b1;
        cyc(10);
        beats_before = beats;
        run_edges(0, 100, 1);
        cyc(50);
        check("first_edge_no_beat", 32'(beats), 32'(beats_before));
        check("first_edge_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
